// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / divide unit: one shift-add or restoring shift-subtract step per clock.
// Optional MULDIV_EARLY_EXIT_EN finishes in one clock when either operand is zero.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             early_q;

  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] early_res;
  logic             early_start;

`ifdef MULDIV_EARLY_EXIT_EN
  assign early_start = (a == '0) || (b == '0);
`else
  assign early_start = 1'b0;
`endif

  // Zero-operand shortcut: divide by zero yields all ones / dividend, everything else 0.
  // lo_q still holds the untouched dividend on the single shortcut step.
  assign early_res = (op_q[1] && (b_q == '0)) ? (op_q[0] ? lo_q : '1) : '0;

  // hi_q:lo_q is the product (multiply) or remainder:quotient-dividend (divide).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (op_q[1]) begin
      shifted = {hi_q, lo_q[WIDTH-1]};
      diff    = shifted - {1'b0, b_q};
      if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
    end
  end

  // NOTE: state is updated with non-blocking assignments only; the async reset clears every register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      early_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            op_q    <= op;
            b_q     <= b;
            hi_q    <= '0;
            lo_q    <= a;
            cnt_q   <= '0;
            early_q <= early_start;
            busy_q  <= ~early_start;
            state_q <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (early_q || (cnt_q == LAST)) begin
            result_q <= early_q ? early_res : (op_q[0] ? hi_d : lo_d);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
